// File: rtl/dma_defs.sv
// Shared definitions for the DMA descriptor-chain engine: FSM state
// encodings (also reported in csr[2:0]), csr bit positions, descriptor
// word offsets and descriptor field bit positions.
package dma_defs;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_FETCH    = 3'd1,
    ST_DISPATCH = 3'd2,
    ST_WAIT     = 3'd3,
    ST_HALT     = 3'd4,
    ST_ERROR    = 3'd5,
    ST_REFETCH  = 3'd6
  } dma_state_t;

  localparam int unsigned CSR_ERR_BIT = 3;
  localparam int unsigned CSR_EOC_BIT = 4;
  localparam int unsigned CSR_INT_BIT = 5;

  localparam logic [1:0] W_NEXT = 2'd0;
  localparam logic [1:0] W_CTRL = 2'd1;
  localparam logic [1:0] W_SRC  = 2'd2;
  localparam logic [1:0] W_DST  = 2'd3;

  localparam int unsigned EOC_BIT    = 0;
  localparam int unsigned INT_EN_BIT = 16;

  typedef struct packed {
    logic [28:0] next;
    logic        eoc;
    logic [15:0] len;
    logic        int_en;
    logic [31:0] src;
    logic [31:0] dst;
  } dma_desc_t;

  // Byte address of descriptor word 'beat' for an 8-byte aligned base.
  function automatic logic [31:0] desc_word_adr(input logic [28:0] base,
                                                input logic [1:0]  beat);
    return {base, 3'b000} + {28'd0, beat, 2'b00};
  endfunction

endpackage

// File: rtl/dma_desc_fetch.sv
// 4-beat Wishbone read sequencer for one descriptor. cyc/stb/cab are held
// for the whole burst; each beat ends on ack, err or rty. Completion,
// failure and early stop are reported as one-cycle registered pulses.
// Optional feature macro: DMA_DESC_RTY_EN (rty reissues the beat up to
// RETRY_MAX times; otherwise rty is handled like err).
module dma_desc_fetch
  import dma_defs::*;
#(
  parameter int unsigned RETRY_MAX = 4
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        start,
  input  logic [28:0] start_adr,
  input  logic        stop,
  output logic [31:0] wbm_adr_o,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_cab_o,
  input  logic [31:0] wbm_dat_i,
  input  logic        wbm_ack_i,
  input  logic        wbm_err_i,
  input  logic        wbm_rty_i,
  output logic        done,
  output logic        fail,
  output logic        stopped,
  output dma_desc_t   desc
);

`ifdef DMA_DESC_RTY_EN
  localparam bit RTY_EN = 1'b1;
`else
  localparam bit RTY_EN = 1'b0;
`endif

  localparam int unsigned CW = $clog2(RETRY_MAX + 1);

  logic          active;
  logic [1:0]    beat;
  logic [28:0]   base;
  logic [CW-1:0] rty_cnt;
  logic          rty_ok;

  assign rty_ok    = RTY_EN && (32'(rty_cnt) < RETRY_MAX);
  assign wbm_adr_o = desc_word_adr(base, beat);
  assign wbm_cyc_o = active;
  assign wbm_stb_o = active;
  assign wbm_cab_o = active;

  // Beat sequencing, word capture and retry accounting.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      active  <= 1'b0;
      beat    <= '0;
      base    <= '0;
      rty_cnt <= '0;
      done    <= 1'b0;
      fail    <= 1'b0;
      stopped <= 1'b0;
      desc    <= '0;
    end else begin
      done    <= 1'b0;
      fail    <= 1'b0;
      stopped <= 1'b0;
      if (!active) begin
        if (start) begin
          active  <= 1'b1;
          beat    <= '0;
          base    <= start_adr;
          rty_cnt <= '0;
        end
      end else if (wbm_ack_i) begin
        rty_cnt <= '0;
        case (beat)
          W_NEXT: begin
            desc.next <= wbm_dat_i[31:3];
            desc.eoc  <= wbm_dat_i[EOC_BIT];
          end
          W_CTRL: begin
            desc.len    <= wbm_dat_i[15:0];
            desc.int_en <= wbm_dat_i[INT_EN_BIT];
          end
          W_SRC:   desc.src <= wbm_dat_i;
          default: desc.dst <= wbm_dat_i;
        endcase
        // An engine disable lets the current beat land, then drops the burst.
        if (stop) begin
          active  <= 1'b0;
          stopped <= 1'b1;
        end else if (beat == W_DST) begin
          active <= 1'b0;
          done   <= 1'b1;
        end else begin
          beat <= beat + 2'd1;
        end
      end else if (wbm_err_i || (wbm_rty_i && !rty_ok)) begin
        active <= 1'b0;
        fail   <= 1'b1;
      end else if (wbm_rty_i) begin
        rty_cnt <= rty_cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/dma_desc_ctrl.sv
// Descriptor-chain control engine: loads descriptor addresses from the
// register block, fetches descriptors, dispatches them to the data mover
// and reports status, interrupts and consume pulses back.
// Optional feature macro: DMA_DESC_RTY_EN (bus retry handling in the fetcher).
module dma_desc_ctrl
  import dma_defs::*;
#(
  parameter int unsigned RETRY_MAX = 4
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        enable,
  input  logic [28:0] ndar,
  input  logic        ndar_dirty,
  input  logic        resume,
  input  logic        int_ack,
  output logic        ndar_dirty_clear,
  output logic        resume_clear,
  output logic        int_ack_clear,
  output logic [31:0] dar,
  output logic [7:0]  csr,
  output logic        busy,
  output logic        wb_int_o,
  output logic [31:0] wbm_adr_o,
  output logic [3:0]  wbm_sel_o,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic        wbm_cab_o,
  input  logic [31:0] wbm_dat_i,
  input  logic        wbm_ack_i,
  input  logic        wbm_err_i,
  input  logic        wbm_rty_i,
  output logic        job_valid,
  input  logic        job_ready,
  output logic [15:0] job_len,
  output logic [31:0] job_src,
  output logic [31:0] job_dst,
  input  logic        job_done,
  input  logic        job_err
);

  dma_state_t  state, state_nxt;
  logic [28:0] dar_q, dar_nxt;
  logic        take_ndar, take_resume, int_set;
  logic        fetch_start, fetch_done, fetch_fail, fetch_stopped;
  dma_desc_t   desc;
  logic        err_q, eoc_q, int_pend;

  assign fetch_start = ((state_nxt == ST_FETCH) || (state_nxt == ST_REFETCH))
                       && (state_nxt != state);

  dma_desc_fetch #(
    .RETRY_MAX(RETRY_MAX)
  ) u_fetch (
    .wb_clk_i  (wb_clk_i),
    .wb_rst_i  (wb_rst_i),
    .start     (fetch_start),
    .start_adr (dar_nxt),
    .stop      (!enable),
    .wbm_adr_o (wbm_adr_o),
    .wbm_cyc_o (wbm_cyc_o),
    .wbm_stb_o (wbm_stb_o),
    .wbm_cab_o (wbm_cab_o),
    .wbm_dat_i (wbm_dat_i),
    .wbm_ack_i (wbm_ack_i),
    .wbm_err_i (wbm_err_i),
    .wbm_rty_i (wbm_rty_i),
    .done      (fetch_done),
    .fail      (fetch_fail),
    .stopped   (fetch_stopped),
    .desc      (desc)
  );

  assign wbm_sel_o = 4'b1111;
  assign wbm_we_o  = 1'b0;
  assign dar       = {dar_q, 3'b000};
  assign wb_int_o  = int_pend;
  assign job_len   = desc.len;
  assign job_src   = desc.src;
  assign job_dst   = desc.dst;

  // State register.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  // Next state, next descriptor address and consume/interrupt requests.
  always_comb begin
    state_nxt   = state;
    dar_nxt     = dar_q;
    take_ndar   = 1'b0;
    take_resume = 1'b0;
    int_set     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (enable && ndar_dirty) begin
          state_nxt = ST_FETCH;
          dar_nxt   = ndar;
          take_ndar = 1'b1;
        end
      end
      ST_FETCH: begin
        if (fetch_fail)         state_nxt = ST_ERROR;
        else if (fetch_stopped) state_nxt = ST_IDLE;
        else if (fetch_done)    state_nxt = ST_DISPATCH;
      end
      // Resume refetch: only next/eoc matter, the job itself is not re-run.
      ST_REFETCH: begin
        if (fetch_fail)         state_nxt = ST_ERROR;
        else if (fetch_stopped) state_nxt = ST_IDLE;
        else if (fetch_done) begin
          if (desc.eoc) begin
            state_nxt = ST_HALT;
          end else begin
            state_nxt = ST_FETCH;
            dar_nxt   = desc.next;
          end
        end
      end
      ST_DISPATCH: begin
        if (job_ready) state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (job_done) begin
          if (job_err) begin
            state_nxt = ST_ERROR;
          end else begin
            int_set = desc.int_en;
            if (desc.eoc)    state_nxt = ST_HALT;
            else if (!enable) state_nxt = ST_IDLE;
            else begin
              state_nxt = ST_FETCH;
              dar_nxt   = desc.next;
            end
          end
        end
      end
      ST_HALT: begin
        if (ndar_dirty) begin
          state_nxt = ST_FETCH;
          dar_nxt   = ndar;
          take_ndar = 1'b1;
        end else if (resume) begin
          state_nxt   = ST_REFETCH;
          take_resume = 1'b1;
        end
      end
      ST_ERROR: begin
        if (!enable) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Status outputs decoded from state and status flags.
  always_comb begin
    job_valid        = (state == ST_DISPATCH);
    busy             = !((state == ST_IDLE) || (state == ST_HALT) || (state == ST_ERROR));
    csr              = '0;
    csr[2:0]         = state;
    csr[CSR_ERR_BIT] = err_q;
    csr[CSR_EOC_BIT] = eoc_q;
    csr[CSR_INT_BIT] = int_pend;
  end

  // Descriptor address, status flags and registered consume pulses.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      dar_q            <= '0;
      err_q            <= 1'b0;
      eoc_q            <= 1'b0;
      int_pend         <= 1'b0;
      ndar_dirty_clear <= 1'b0;
      resume_clear     <= 1'b0;
      int_ack_clear    <= 1'b0;
    end else begin
      dar_q            <= dar_nxt;
      err_q            <= (state_nxt == ST_ERROR);
      ndar_dirty_clear <= take_ndar;
      resume_clear     <= take_resume;
      // Held int_ack still yields a single-cycle clear pulse.
      int_ack_clear    <= int_ack && !int_ack_clear;
      if (fetch_done) eoc_q <= desc.eoc;
      // A new interrupt source beats a simultaneous acknowledge.
      if (int_set || ((state_nxt == ST_ERROR) && (state != ST_ERROR)))
        int_pend <= 1'b1;
      else if (int_ack)
        int_pend <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dma_desc_ctrl.sv
// Scoreboard bench for dma_desc_ctrl: directed stimulus pushes expected bus
// reads and jobs into queues; monitors pop and compare on each bus
// termination and each job handshake.
module tb_dma_desc_ctrl;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i;
  logic        enable, ndar_dirty, resume, int_ack;
  logic [28:0] ndar;
  logic        ndar_dirty_clear, resume_clear, int_ack_clear;
  logic [31:0] dar;
  logic [7:0]  csr;
  logic        busy, wb_int_o;
  logic [31:0] wbm_adr_o;
  logic [3:0]  wbm_sel_o;
  logic        wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_cab_o;
  logic [31:0] wbm_dat_i = '0;
  logic        wbm_ack_i = 1'b0, wbm_err_i = 1'b0, wbm_rty_i = 1'b0;
  logic        job_valid, job_ready, job_done, job_err;
  logic [15:0] job_len;
  logic [31:0] job_src, job_dst;

  always #5 wb_clk_i = ~wb_clk_i;

  dma_desc_ctrl #(.RETRY_MAX(4)) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i), .enable(enable), .ndar(ndar),
    .ndar_dirty(ndar_dirty), .resume(resume), .int_ack(int_ack),
    .ndar_dirty_clear(ndar_dirty_clear), .resume_clear(resume_clear),
    .int_ack_clear(int_ack_clear), .dar(dar), .csr(csr), .busy(busy),
    .wb_int_o(wb_int_o), .wbm_adr_o(wbm_adr_o), .wbm_sel_o(wbm_sel_o),
    .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
    .wbm_cab_o(wbm_cab_o), .wbm_dat_i(wbm_dat_i), .wbm_ack_i(wbm_ack_i),
    .wbm_err_i(wbm_err_i), .wbm_rty_i(wbm_rty_i), .job_valid(job_valid),
    .job_ready(job_ready), .job_len(job_len), .job_src(job_src),
    .job_dst(job_dst), .job_done(job_done), .job_err(job_err)
  );

  typedef struct {
    logic [15:0] len;
    logic [31:0] src;
    logic [31:0] dst;
  } job_t;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] exp_rd[$];
  job_t        exp_job[$];

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endfunction

  // Memory-backed zero-wait-state slave with injectable rty/err on one address.
  logic [31:0] mem [0:4095];
  logic [31:0] rty_adr = '1, err_adr = '1;
  int          rty_budget = 0, rty_used = 0, err_budget = 0, err_used = 0;

  always @(negedge wb_clk_i) begin
    wbm_ack_i = 1'b0;
    wbm_err_i = 1'b0;
    wbm_rty_i = 1'b0;
    if (wbm_cyc_o && wbm_stb_o) begin
      if (wbm_adr_o == rty_adr && rty_used < rty_budget) begin
        wbm_rty_i = 1'b1;
        rty_used++;
      end else if (wbm_adr_o == err_adr && err_used < err_budget) begin
        wbm_err_i = 1'b1;
        err_used++;
      end else begin
        wbm_ack_i = 1'b1;
        wbm_dat_i = mem[wbm_adr_o[13:2]];
      end
    end
  end

  // Bus monitor: every terminated beat must match the next expected address.
  always @(negedge wb_clk_i) begin
    #2;
    if (wbm_cyc_o && wbm_stb_o && (wbm_ack_i || wbm_err_i || wbm_rty_i)) begin
      if (exp_rd.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rd_unexpected: got adr 0x%08h expected no read", wbm_adr_o);
      end else begin
        chk("rd_adr", wbm_adr_o, exp_rd.pop_front());
        chk("rd_cab", {31'd0, wbm_cab_o}, 32'd1);
      end
    end
  end

  // Job monitor: offered fields must match the expected job while valid.
  always @(negedge wb_clk_i) begin
    #2;
    if (job_valid) begin
      if (exp_job.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL job_unexpected: got len 0x%04h expected no job", job_len);
      end else begin
        job_t j;
        j = exp_job[0];
        chk("job_len", {16'd0, job_len}, {16'd0, j.len});
        chk("job_src", job_src, j.src);
        chk("job_dst", job_dst, j.dst);
        if (job_ready) void'(exp_job.pop_front());
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(negedge wb_clk_i);
  endtask

  task automatic push_reads(input logic [31:0] a);
    for (int i = 0; i < 4; i++) exp_rd.push_back(a + 32'(4 * i));
  endtask

  task automatic push_job(input logic [15:0] l, input logic [31:0] s, input logic [31:0] d);
    job_t j;
    j.len = l; j.src = s; j.dst = d;
    exp_job.push_back(j);
  endtask

  task automatic set_desc(input logic [31:0] a, input logic [31:0] w0, input logic [31:0] w1,
                          input logic [31:0] w2, input logic [31:0] w3);
    mem[a[13:2]]       = w0;
    mem[a[13:2] + 12'd1] = w1;
    mem[a[13:2] + 12'd2] = w2;
    mem[a[13:2] + 12'd3] = w3;
  endtask

  task automatic kick(input logic [31:0] a);
    ndar       = a[31:3];
    ndar_dirty = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (ndar_dirty_clear) break;
    end
    chk("ndar_dirty_clear", {31'd0, ndar_dirty_clear}, 32'd1);
    ndar_dirty = 1'b0;
  endtask

  task automatic wait_state(input logic [2:0] s, input string name);
    int k = 0;
    while (csr[2:0] != s && k < 80) begin
      tick();
      k++;
    end
    chk(name, {29'd0, csr[2:0]}, {29'd0, s});
  endtask

  task automatic do_job(input int hold, input logic err, input logic ack_same, input logic [31:0] exp_dar);
    int k = 0;
    while (!job_valid && k < 80) begin
      tick();
      k++;
    end
    chk("job_valid_seen", {31'd0, job_valid}, 32'd1);
    chk("job_dar", dar, exp_dar);
    tick(hold);
    job_ready = 1'b1;
    tick();
    job_ready = 1'b0;
    chk("wait_state", {29'd0, csr[2:0]}, 32'd3);
    chk("wait_busy", {31'd0, busy}, 32'd1);
    tick(2);
    job_done = 1'b1;
    job_err  = err;
    if (ack_same) int_ack = 1'b1;
    tick();
    job_done = 1'b0;
    job_err  = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = '0;
    wb_rst_i = 1'b1; enable = 1'b0; ndar = '0; ndar_dirty = 1'b0;
    resume = 1'b0; int_ack = 1'b0; job_ready = 1'b0; job_done = 1'b0; job_err = 1'b0;
    tick(3);
    chk("rst_csr", {24'd0, csr}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_int", {31'd0, wb_int_o}, 32'd0);
    chk("rst_cyc", {31'd0, wbm_cyc_o}, 32'd0);
    chk("rst_job_valid", {31'd0, job_valid}, 32'd0);
    chk("rst_dar", dar, 32'd0);
    chk("rst_clears", {29'd0, ndar_dirty_clear, resume_clear, int_ack_clear}, 32'd0);
    wb_rst_i = 1'b0;
    tick();

    // Single descriptor, mover stalls ready for two cycles.
    set_desc(32'h1000, 32'h1, 32'h10040, 32'h2000, 32'h3000);
    enable = 1'b1;
    push_reads(32'h1000);
    push_job(16'h40, 32'h2000, 32'h3000);
    kick(32'h1000);
    chk("kick_dar", dar, 32'h1000);
    chk("kick_busy", {31'd0, busy}, 32'd1);
    do_job(2, 1'b0, 1'b0, 32'h1000);
    chk("single_csr", {24'd0, csr}, 32'h34);
    chk("single_int", {31'd0, wb_int_o}, 32'd1);
    chk("single_busy", {31'd0, busy}, 32'd0);
    int_ack = 1'b1;
    tick();
    chk("ack_clear_pulse", {31'd0, int_ack_clear}, 32'd1);
    chk("ack_int_low", {31'd0, wb_int_o}, 32'd0);
    int_ack = 1'b0;
    tick();
    chk("ack_clear_once", {31'd0, int_ack_clear}, 32'd0);

    // Resume after software appends a descriptor at 0x1100.
    mem[12'h400] = 32'h1100;
    set_desc(32'h1100, 32'h1, 32'h50, 32'h4000, 32'h5000);
    push_reads(32'h1000);
    push_reads(32'h1100);
    push_job(16'h50, 32'h4000, 32'h5000);
    resume = 1'b1;
    tick();
    chk("resume_clear_pulse", {31'd0, resume_clear}, 32'd1);
    resume = 1'b0;
    tick();
    chk("resume_clear_once", {31'd0, resume_clear}, 32'd0);
    do_job(0, 1'b0, 1'b0, 32'h1100);
    chk("resume_halt", {29'd0, csr[2:0]}, 32'd4);
    chk("no_int_en", {31'd0, wb_int_o}, 32'd0);

    // Chain of two; second completion races an interrupt acknowledge.
    set_desc(32'h1200, 32'h1300, 32'h10020, 32'h6000, 32'h7000);
    set_desc(32'h1300, 32'h1, 32'h10010, 32'h8000, 32'h9000);
    push_reads(32'h1200);
    push_job(16'h20, 32'h6000, 32'h7000);
    push_reads(32'h1300);
    push_job(16'h10, 32'h8000, 32'h9000);
    kick(32'h1200);
    do_job(1, 1'b0, 1'b0, 32'h1200);
    do_job(0, 1'b0, 1'b1, 32'h1300);
    chk("race_clear_pulse", {31'd0, int_ack_clear}, 32'd1);
    chk("race_int_kept", {31'd0, wb_int_o}, 32'd1);
    chk("race_csr", {24'd0, csr}, 32'h34);
    int_ack = 1'b0;
    tick();
    chk("race_clear_once", {31'd0, int_ack_clear}, 32'd0);
    chk("race_int_still", {31'd0, wb_int_o}, 32'd1);

    // Resume with eoc still set: refetch only, back to HALT.
    push_reads(32'h1300);
    resume = 1'b1;
    tick();
    resume = 1'b0;
    tick(2);
    wait_state(3'd4, "refetch_halt");
    chk("refetch_dar", dar, 32'h1300);
    int_ack = 1'b1;
    tick();
    int_ack = 1'b0;
    tick();
    chk("int_cleared", {31'd0, wb_int_o}, 32'd0);

    // Bus error on beat 2.
    err_adr    = 32'h1008;
    err_budget = err_used + 1;
    exp_rd.push_back(32'h1000);
    exp_rd.push_back(32'h1004);
    exp_rd.push_back(32'h1008);
    kick(32'h1000);
    wait_state(3'd5, "err_state");
    chk("err_bit", {31'd0, csr[3]}, 32'd1);
    chk("err_int", {31'd0, wb_int_o}, 32'd1);
    chk("err_busy", {31'd0, busy}, 32'd0);
    enable = 1'b0;
    tick();
    wait_state(3'd0, "err_exit_idle");
    chk("err_bit_clr", {31'd0, csr[3]}, 32'd0);
    int_ack = 1'b1;
    tick();
    int_ack = 1'b0;

    // Enable dropped during fetch: current beat completes, no dispatch.
    enable = 1'b1;
    exp_rd.push_back(32'h1000);
    kick(32'h1000);
    enable = 1'b0;
    tick(3);
    chk("abort_idle", {29'd0, csr[2:0]}, 32'd0);
    chk("abort_cyc", {31'd0, wbm_cyc_o}, 32'd0);

    enable = 1'b1;
`ifdef DMA_DESC_RTY_EN
    mem[12'h400] = 32'h1;
    rty_adr    = 32'h1004;
    rty_budget = rty_used + 3;
    exp_rd.push_back(32'h1000);
    repeat (4) exp_rd.push_back(32'h1004);
    exp_rd.push_back(32'h1008);
    exp_rd.push_back(32'h100C);
    push_job(16'h40, 32'h2000, 32'h3000);
    kick(32'h1000);
    do_job(0, 1'b0, 1'b0, 32'h1000);
    chk("rty3_halt", {29'd0, csr[2:0]}, 32'd4);
    chk("rty3_no_err", {31'd0, csr[3]}, 32'd0);
    rty_adr    = 32'h1008;
    rty_budget = rty_used + 5;
    exp_rd.push_back(32'h1000);
    exp_rd.push_back(32'h1004);
    repeat (5) exp_rd.push_back(32'h1008);
    kick(32'h1000);
    wait_state(3'd5, "rty5_err");
`else
    rty_adr    = 32'h1004;
    rty_budget = rty_used + 1;
    exp_rd.push_back(32'h1000);
    exp_rd.push_back(32'h1004);
    kick(32'h1000);
    wait_state(3'd5, "rty_as_err");
`endif
    chk("rty_err_bit", {31'd0, csr[3]}, 32'd1);
    enable = 1'b0;
    tick();
    wait_state(3'd0, "rty_exit_idle");

    tick(3);
    chk("rd_queue_empty", 32'(exp_rd.size()), 32'd0);
    chk("job_queue_empty", 32'(exp_job.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
